// File: rtl/tlda_cmd_queue.sv
// Avalon-MM command queue for the line-drawing accelerator: software stages a line
// description, pushes it into a FIFO, and a small dispatcher feeds entries to the LDA.
module tlda_cmd_queue #(
    parameter int XW    = 9,
    parameter int YW    = 8,
    parameter int CW    = 16,
    parameter int TW    = 9,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          slave_chipselect,
    input  logic [2:0]    slave_address,
    input  logic          slave_read,
    input  logic          slave_write,
    input  logic [31:0]   slave_writedata,
    output logic [31:0]   slave_readdata,
    input  logic          Done_from_LDA,
    output logic          Go_to_LDA,
    output logic [XW-1:0] X0_to_LDA,
    output logic [XW-1:0] X1_to_LDA,
    output logic [YW-1:0] Y0_to_LDA,
    output logic [YW-1:0] Y1_to_LDA,
    output logic [CW-1:0] Color_to_LDA,
    output logic [TW-1:0] Thickness,
    output logic [31:0]   Base_Addr_to_LDA
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;

    typedef struct packed {
        logic [XW-1:0] x0;
        logic [YW-1:0] y0;
        logic [XW-1:0] x1;
        logic [YW-1:0] y1;
        logic [CW-1:0] color;
        logic [TW-1:0] thick;
        logic [31:0]   base;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } state_t;

    state_t        state;
    state_t        state_nx;
    cmd_t          stage;
    cmd_t          cur;
    cmd_t          head;
    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] count;
    logic          overflow;
    logic          pause;
    logic          done_q;

    logic          wr_en;
    logic          push_req;
    logic          push_ok;
    logic          ctrl_wr;
    logic          flush;
    logic          full;
    logic          empty;
    logic          pop;
    logic          done_rise;
    logic          unused_wd;

    assign wr_en     = slave_chipselect && slave_write;
    assign push_req  = wr_en && (slave_address == 3'd1);
    assign ctrl_wr   = wr_en && (slave_address == 3'd7);
    assign flush     = ctrl_wr && slave_writedata[1];
    assign full      = (count == NW'(DEPTH));
    assign empty     = (count == '0);
    // Fullness is judged before any same-cycle pop, so a push into a full FIFO always drops.
    assign push_ok   = push_req && !full;
    assign pop       = (state == IDLE) && !empty && !pause;
    assign done_rise = Done_from_LDA && !done_q;
    assign head      = mem[rd_ptr];
    assign unused_wd = ^slave_writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage <= '0;
        end else if (wr_en) begin
            unique case (slave_address)
                3'd2: begin
                    stage.x0 <= slave_writedata[XW-1:0];
                    stage.y0 <= slave_writedata[XW+YW-1:XW];
                end
                3'd3: begin
                    stage.x1 <= slave_writedata[XW-1:0];
                    stage.y1 <= slave_writedata[XW+YW-1:XW];
                end
                3'd4:    stage.color <= slave_writedata[CW-1:0];
                3'd5:    stage.thick <= slave_writedata[TW-1:0];
                3'd6:    stage.base  <= slave_writedata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= stage;
        end
    end

    // A flush wins over pointer motion; a pop in the same cycle still launches the head entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            pause    <= 1'b0;
            done_q   <= 1'b0;
            cur      <= '0;
        end else begin
            done_q <= Done_from_LDA;
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (ctrl_wr && slave_writedata[0]) begin
                overflow <= 1'b0;
            end
            if (ctrl_wr) begin
                pause <= slave_writedata[2];
            end
            if (pop) begin
                cur <= head;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pop) state_nx = LAUNCH;
            LAUNCH:  state_nx = WAIT;
            WAIT:    if (done_rise) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        slave_readdata = '0;
        if (slave_chipselect && slave_read) begin
            unique case (slave_address)
                3'd0: begin
                    slave_readdata[0]      = empty && (state == IDLE);
                    slave_readdata[1]      = full;
                    slave_readdata[2]      = overflow;
                    slave_readdata[3]      = pause;
                    slave_readdata[8 +: NW] = count;
                end
                3'd2:    slave_readdata[XW+YW-1:0] = {stage.y0, stage.x0};
                3'd3:    slave_readdata[XW+YW-1:0] = {stage.y1, stage.x1};
                3'd4:    slave_readdata[CW-1:0]    = stage.color;
                3'd5:    slave_readdata[TW-1:0]    = stage.thick;
                3'd6:    slave_readdata            = stage.base;
                3'd7:    slave_readdata[2]         = pause;
                default: ;
            endcase
        end
    end

    assign Go_to_LDA        = (state == LAUNCH);
    assign X0_to_LDA        = cur.x0;
    assign Y0_to_LDA        = cur.y0;
    assign X1_to_LDA        = cur.x1;
    assign Y1_to_LDA        = cur.y1;
    assign Color_to_LDA     = cur.color;
    assign Thickness        = cur.thick;
    assign Base_Addr_to_LDA = cur.base;

endmodule

// File: tb/tb_tlda_cmd_queue.sv
// Self-checking bench for tlda_cmd_queue: directed scenarios plus randomized command
// streams compared against a queue-based reference model.
module tb_tlda_cmd_queue;

    localparam int XW    = 9;
    localparam int YW    = 8;
    localparam int CW    = 16;
    localparam int TW    = 9;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [XW-1:0] x0;
        logic [YW-1:0] y0;
        logic [XW-1:0] x1;
        logic [YW-1:0] y1;
        logic [CW-1:0] color;
        logic [TW-1:0] thick;
        logic [31:0]   base;
    } cmd_t;

    logic          clk;
    logic          reset;
    logic          cs;
    logic [2:0]    addr;
    logic          rd;
    logic          wr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          done_in;
    logic          manual_done;
    logic          auto_done;
    logic          auto_en;
    logic          go;
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y0;
    logic [YW-1:0] y1;
    logic [CW-1:0] color;
    logic [TW-1:0] thick;
    logic [31:0]   base;

    int   checks = 0;
    int   errors = 0;
    int   go_double = 0;
    int   auto_cnt = 0;
    logic prev_go = 1'b0;
    cmd_t go_log[$];

    assign done_in = auto_en ? auto_done : manual_done;

    tlda_cmd_queue #(.XW(XW), .YW(YW), .CW(CW), .TW(TW), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .slave_chipselect (cs),
        .slave_address    (addr),
        .slave_read       (rd),
        .slave_write      (wr),
        .slave_writedata  (wdata),
        .slave_readdata   (rdata),
        .Done_from_LDA    (done_in),
        .Go_to_LDA        (go),
        .X0_to_LDA        (x0),
        .X1_to_LDA        (x1),
        .Y0_to_LDA        (y0),
        .Y1_to_LDA        (y1),
        .Color_to_LDA     (color),
        .Thickness        (thick),
        .Base_Addr_to_LDA (base)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every Go pulse with the command presented alongside it.
    always @(negedge clk) begin
        cmd_t c;
        if (go) begin
            c.x0 = x0; c.y0 = y0; c.x1 = x1; c.y1 = y1;
            c.color = color; c.thick = thick; c.base = base;
            go_log.push_back(c);
            if (prev_go) go_double++;
        end
        prev_go = go;
    end

    // Optional LDA stand-in: Done pulses for one cycle five cycles after each Go.
    always @(negedge clk) begin
        if (!auto_en) begin
            auto_cnt  = 0;
            auto_done = 1'b0;
        end else if (go) begin
            auto_cnt  = 5;
            auto_done = 1'b0;
        end else if (auto_cnt > 0) begin
            auto_cnt--;
            auto_done = (auto_cnt == 0);
        end else begin
            auto_done = 1'b0;
        end
    end

    function automatic logic [31:0] pack_xy(input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [31:0] w;
        w = '0;
        w[XW-1:0]     = x;
        w[XW+YW-1:XW] = y;
        return w;
    endfunction

    function automatic logic [31:0] stage_word(input cmd_t c, input int a);
        logic [31:0] w;
        w = '0;
        case (a)
            2: w = pack_xy(c.x0, c.y0);
            3: w = pack_xy(c.x1, c.y1);
            4: w[CW-1:0] = c.color;
            5: w[TW-1:0] = c.thick;
            6: w = c.base;
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] status_word(input int occ, input bit idle, input bit ovf, input bit pse);
        logic [31:0] w;
        w = '0;
        w[0]    = idle;
        w[1]    = (occ == DEPTH);
        w[2]    = ovf;
        w[3]    = pse;
        w[15:8] = 8'(occ);
        return w;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.x0 = XW'($urandom); c.y0 = YW'($urandom);
        c.x1 = XW'($urandom); c.y1 = YW'($urandom);
        c.color = CW'($urandom); c.thick = TW'($urandom); c.base = $urandom;
        return c;
    endfunction

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1;
        d = rdata;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic stage_cmd(input cmd_t c);
        for (int a = 2; a <= 6; a++) bus_write(3'(a), stage_word(c, a));
    endtask

    task automatic do_reset();
        auto_en = 1'b0; manual_done = 1'b0;
        cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        go_log.delete();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        bus_read(3'd0, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("[TB] FAIL reset_status: got %h expected %h", v, 32'h1); end
        for (int a = 2; a <= 7; a++) begin
            bus_read(3'(a), v);
            checks++;
            if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_reg%0d: got %h expected 0", a, v); end
        end
        checks++;
        if ({go, x0, y0, x1, y1, color, thick, base} !== '0) begin
            errors++; $display("[TB] FAIL reset_outputs: got go=%b x0=%h base=%h expected all 0", go, x0, base);
        end
    endtask

    task automatic test_single_command();
        cmd_t c;
        cmd_t got;
        logic [31:0] v;
        do_reset();
        c = '{x0: 5, y0: 10, x1: 319, y1: 31, color: 16'hF800, thick: 3, base: 32'h0800_0000};
        stage_cmd(c);
        bus_read(3'd2, v);
        checks++;
        if (v !== 32'h0000_1405) begin errors++; $display("[TB] FAIL start_readback: got %h expected %h", v, 32'h1405); end
        bus_write(3'd1, $urandom);
        checks++;
        if (go !== 1'b0) begin errors++; $display("[TB] FAIL go_early: got %b expected 0", go); end
        @(negedge clk);
        got.x0 = x0; got.y0 = y0; got.x1 = x1; got.y1 = y1;
        got.color = color; got.thick = thick; got.base = base;
        checks++;
        if (go !== 1'b1) begin errors++; $display("[TB] FAIL go_pulse: got %b expected 1", go); end
        checks++;
        if (got !== c) begin errors++; $display("[TB] FAIL single_outputs: got %h expected %h", got, c); end
        @(negedge clk);
        checks++;
        if (go !== 1'b0) begin errors++; $display("[TB] FAIL go_width: got %b expected 0", go); end
        repeat (3) begin
            @(negedge clk);
            bus_read(3'd0, v);
            checks++;
            if (v[0] !== 1'b0) begin errors++; $display("[TB] FAIL busy_idle: got %b expected 0", v[0]); end
        end
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        bus_read(3'd0, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("[TB] FAIL done_idle: got %h expected %h", v, 32'h1); end
        checks++;
        if (x1 !== c.x1) begin errors++; $display("[TB] FAIL output_hold: got %h expected %h", x1, c.x1); end
    endtask

    task automatic test_overflow();
        cmd_t c;
        logic [31:0] v;
        do_reset();
        bus_write(3'd7, 32'h4);
        c = rand_cmd();
        stage_cmd(c);
        repeat (9) bus_write(3'd1, 32'h0);
        bus_read(3'd0, v);
        checks++;
        if (v !== status_word(8, 0, 1, 1)) begin errors++; $display("[TB] FAIL ovf_status: got %h expected %h", v, status_word(8, 0, 1, 1)); end
        bus_write(3'd7, 32'h1);
        bus_read(3'd0, v);
        checks++;
        if (v !== status_word(8, 0, 0, 0)) begin errors++; $display("[TB] FAIL ovf_clear: got %h expected %h", v, status_word(8, 0, 0, 0)); end
        bus_write(3'd7, 32'h6);
        bus_read(3'd0, v);
        checks++;
        if (v !== status_word(0, 0, 0, 1)) begin errors++; $display("[TB] FAIL flush_status: got %h expected %h", v, status_word(0, 0, 0, 1)); end
        checks++;
        if (go_log.size() != 1 || go_log[0] !== c) begin
            errors++; $display("[TB] FAIL flush_pop: got %0d pulses expected 1 carrying %h", go_log.size(), c);
        end
        @(negedge clk);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        bus_read(3'd0, v);
        checks++;
        if (v !== status_word(0, 1, 0, 1)) begin errors++; $display("[TB] FAIL flush_idle: got %h expected %h", v, status_word(0, 1, 0, 1)); end
    endtask

    task automatic test_dispatch_order();
        cmd_t q[$];
        cmd_t c;
        logic [31:0] v;
        int waited;
        do_reset();
        bus_write(3'd7, 32'h4);
        for (int i = 0; i < 3; i++) begin
            c = rand_cmd();
            c.color = CW'(i + 1);
            stage_cmd(c);
            bus_write(3'd1, 32'h0);
            q.push_back(c);
        end
        auto_en = 1'b1;
        bus_write(3'd7, 32'h0);
        waited = 0;
        while (go_log.size() < 3 && waited < 100) begin @(negedge clk); #1; waited++; end
        checks++;
        if (go_log.size() != 3) begin errors++; $display("[TB] FAIL order_timeout: got %0d pulses expected 3", go_log.size()); end
        for (int i = 0; i < go_log.size() && i < 3; i++) begin
            checks++;
            if (go_log[i] !== q[i]) begin errors++; $display("[TB] FAIL order_entry%0d: got %h expected %h", i, go_log[i], q[i]); end
        end
        repeat (10) @(negedge clk);
        bus_read(3'd0, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("[TB] FAIL order_idle: got %h expected %h", v, 32'h1); end
        checks++;
        if (go_double != 0) begin errors++; $display("[TB] FAIL go_single_cycle: got %0d long pulses expected 0", go_double); end
        auto_en = 1'b0;
    endtask

    task automatic test_done_edge();
        logic [31:0] v;
        do_reset();
        stage_cmd(rand_cmd());
        manual_done = 1'b1;
        bus_write(3'd1, 32'h0);
        @(negedge clk);
        checks++;
        if (go !== 1'b1) begin errors++; $display("[TB] FAIL held_done_go: got %b expected 1", go); end
        repeat (4) begin
            @(negedge clk);
            bus_read(3'd0, v);
            checks++;
            if (v[0] !== 1'b0) begin errors++; $display("[TB] FAIL held_done_wait: got idle %b expected 0", v[0]); end
        end
        manual_done = 1'b0;
        @(negedge clk);
        bus_read(3'd0, v);
        checks++;
        if (v[0] !== 1'b0) begin errors++; $display("[TB] FAIL done_low_wait: got idle %b expected 0", v[0]); end
        manual_done = 1'b1;
        @(negedge clk);
        bus_read(3'd0, v);
        checks++;
        if (v[0] !== 1'b1) begin errors++; $display("[TB] FAIL done_rise_idle: got idle %b expected 1", v[0]); end
        manual_done = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        cmd_t c;
        logic [31:0] v;
        int waited;
        int n0;
        do_reset();
        bus_write(3'd7, 32'h4);
        c = rand_cmd();
        c.x0 = c.x0 | XW'(1); c.y0 = c.y0 | YW'(1); c.x1 = c.x1 | XW'(1); c.y1 = c.y1 | YW'(1);
        c.color = c.color | CW'(1); c.thick = c.thick | TW'(1); c.base = c.base | 32'h1;
        stage_cmd(c);
        repeat (5) bus_write(3'd1, 32'h0);
        bus_write(3'd7, 32'h0);
        waited = 0;
        while (go_log.size() < 1 && waited < 10) begin @(negedge clk); #1; waited++; end
        checks++;
        if (go_log.size() != 1) begin errors++; $display("[TB] FAIL rst_go_timeout: got %0d pulses expected 1", go_log.size()); end
        @(negedge clk);
        bus_read(3'd0, v);
        checks++;
        if (v !== status_word(4, 0, 0, 0)) begin errors++; $display("[TB] FAIL rst_pre_status: got %h expected %h", v, status_word(4, 0, 0, 0)); end
        checks++;
        if (base !== c.base) begin errors++; $display("[TB] FAIL rst_pre_base: got %h expected %h", base, c.base); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({go, x0, y0, x1, y1, color, thick, base} !== '0) begin
            errors++; $display("[TB] FAIL rst_async_outputs: got x0=%h color=%h base=%h expected all 0", x0, color, base);
        end
        bus_read(3'd0, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("[TB] FAIL rst_async_status: got %h expected %h", v, 32'h1); end
        @(negedge clk);
        reset = 1'b0;
        n0 = go_log.size();
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (go_log.size() != n0) begin errors++; $display("[TB] FAIL rst_no_go: got %0d pulses expected %0d", go_log.size(), n0); end
    endtask

    task automatic test_unpause_full_push();
        logic [31:0] v;
        do_reset();
        bus_write(3'd7, 32'h4);
        stage_cmd(rand_cmd());
        repeat (8) bus_write(3'd1, 32'h0);
        bus_read(3'd0, v);
        checks++;
        if (v !== status_word(8, 0, 0, 1)) begin errors++; $display("[TB] FAIL full_status: got %h expected %h", v, status_word(8, 0, 0, 1)); end
        bus_write(3'd7, 32'h0);
        bus_write(3'd1, 32'h0);
        bus_read(3'd0, v);
        checks++;
        if (v !== status_word(7, 0, 1, 0)) begin errors++; $display("[TB] FAIL pop_push_status: got %h expected %h", v, status_word(7, 0, 1, 0)); end
        checks++;
        if (go !== 1'b1) begin errors++; $display("[TB] FAIL pop_push_go: got %b expected 1", go); end
    endtask

    task automatic test_random();
        cmd_t q[$];
        cmd_t c;
        logic [31:0] v;
        int n;
        int a;
        int waited;
        bit ovf;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            q.delete();
            ovf = 0;
            bus_write(3'd7, 32'h4);
            n = $urandom_range(3, 12);
            for (int i = 0; i < n; i++) begin
                c = rand_cmd();
                stage_cmd(c);
                a = $urandom_range(2, 6);
                bus_read(3'(a), v);
                checks++;
                if (v !== stage_word(c, a)) begin errors++; $display("[TB] FAIL rand_readback%0d: got %h expected %h", a, v, stage_word(c, a)); end
                bus_write(3'd1, $urandom);
                if (q.size() < DEPTH) q.push_back(c);
                else ovf = 1;
            end
            bus_read(3'd0, v);
            checks++;
            if (v !== status_word(q.size(), 0, ovf, 1)) begin
                errors++; $display("[TB] FAIL rand_status: got %h expected %h", v, status_word(q.size(), 0, ovf, 1));
            end
            auto_en = 1'b1;
            bus_write(3'd7, 32'h0);
            waited = 0;
            while (go_log.size() < q.size() && waited < 20 * DEPTH) begin @(negedge clk); #1; waited++; end
            checks++;
            if (go_log.size() != q.size()) begin errors++; $display("[TB] FAIL rand_timeout: got %0d pulses expected %0d", go_log.size(), q.size()); end
            for (int i = 0; i < go_log.size() && i < q.size(); i++) begin
                checks++;
                if (go_log[i] !== q[i]) begin errors++; $display("[TB] FAIL rand_entry%0d: got %h expected %h", i, go_log[i], q[i]); end
            end
            repeat (10) @(negedge clk);
            bus_read(3'd0, v);
            checks++;
            if (v !== status_word(0, 1, ovf, 0)) begin errors++; $display("[TB] FAIL rand_idle: got %h expected %h", v, status_word(0, 1, ovf, 0)); end
            auto_en = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_command();
        test_overflow();
        test_dispatch_order();
        test_done_edge();
        test_reset_mid_wait();
        test_unpause_full_push();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlda_cmd_queue.md
TLDA_CMD_QUEUE -- requirements
Module: tlda_cmd_queue

Interface
REQ-001 The block SHALL have parameter XW, default 9, giving the X coordinate width.
REQ-002 The block SHALL have parameter YW, default 8, giving the Y coordinate width; XW+YW SHALL be at most 32.
REQ-003 The block SHALL have parameter CW, default 16, giving the colour width.
REQ-004 The block SHALL have parameter TW, default 9, giving the thickness width.
REQ-005 The block SHALL have parameter DEPTH, default 8, giving the command FIFO depth; DEPTH SHALL be a power of 2 in the range 2..128.
REQ-006 The block SHALL have the following ports:
 clk  in  1  sole clock, rising edge;
 reset  in  1  asynchronous, active-high reset;
 slave_chipselect  in  1  Avalon select;
 slave_address  in  3  word address;
 slave_read  in  1  read strobe;
 slave_write  in  1  write strobe;
 slave_writedata  in  32  write data;
 slave_readdata  out  32  read data, combinational, 0 unless chipselect&read;
 Done_from_LDA  in  1  LDA completion;
 Go_to_LDA  out  1  one-cycle start pulse;
 X0_to_LDA, X1_to_LDA  out  XW  endpoint X;
 Y0_to_LDA, Y1_to_LDA  out  YW  endpoint Y;
 Color_to_LDA  out  CW  colour;
 Thickness  out  TW  line thickness;
 Base_Addr_to_LDA  out  32  frame-buffer base.

Function
REQ-007 The address map SHALL be: 0 STATUS (RO); 1 PUSH (WO); 2 START; 3 END; 4 COLOR; 5 THICKNESS; 6 BASE_ADDR; 7 CONTROL.
REQ-008 Writes to addresses 2..6 SHALL load staging registers (START/END: X=wd[XW-1:0], Y=wd[XW+YW-1:XW]; others low-aligned); reads SHALL return staging values zero-extended.
REQ-009 A write to PUSH, any data, SHALL enqueue one entry {staging X0,Y0,X1,Y1,colour,thickness,base} if the FIFO is not full; staging registers SHALL be unchanged.
REQ-010 PUSH while full SHALL discard the command and set sticky overflow; a same-cycle pop SHALL NOT count as not-full.
REQ-011 STATUS read SHALL return bit0 idle (FIFO empty and FSM IDLE), bit1 full, bit2 overflow, bit3 pause, bits[15:8] occupancy (0..DEPTH), remaining bits 0.
REQ-012 A write to CONTROL SHALL perform: wd[0]=1 clears overflow; wd[1]=1 flushes the FIFO (occupancy 0 next cycle); pause loads wd[2]; a CONTROL read SHALL return pause in bit2.
REQ-013 A flush and a PUSH cannot coincide (same bus write); a flush in the cycle the FSM pops SHALL leave the popped command executing.
REQ-014 Dispatcher FSM states SHALL be IDLE, LAUNCH and WAIT.
REQ-015 IDLE -> LAUNCH SHALL occur when FIFO not empty and pause=0; the head entry SHALL be popped into the output registers on that edge.
REQ-016 In LAUNCH, Go_to_LDA SHALL be 1 for exactly one cycle; LAUNCH -> WAIT unconditionally.
REQ-017 WAIT -> IDLE SHALL occur on a rising edge of Done_from_LDA (Done=1 this cycle, 0 the previous cycle); Done SHALL be ignored in IDLE and LAUNCH.
REQ-018 Output registers SHALL hold from pop until the next pop; minimum pop-to-pop spacing is 3 cycles.
REQ-019 Setting pause SHALL NOT abort a command in LAUNCH/WAIT; it blocks only the next pop.
REQ-020 Occupancy SHALL be unchanged on simultaneous accepted push and pop; read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-021 Asserting reset SHALL, asynchronously: FSM to IDLE, occupancy and pointers 0, overflow 0, pause 0, staging and output registers 0, Go_to_LDA 0.
REQ-022 Reset mid-WAIT SHALL abandon the command without a further Go pulse; the Done-edge detector SHALL reset to 0.

Verification
REQ-023 Stage START=0x00A_05, END=0x1F_13F, COLOR=0xF800, THICK=3, BASE=0x0800_0000, PUSH -> one Go pulse 2 cycles after the write edge with X0=5, Y0=10, X1=319, Y1=31; STATUS bit0=0 until Done rises, then 1.
REQ-024 Nine PUSHes with pause=1, DEPTH=8 -> occupancy 8, full=1, overflow=1; write CONTROL=0x1 -> overflow=0, occupancy still 8.
REQ-025 Three distinct commands queued, pause=0, Done pulses 5 cycles after each Go -> three Go pulses in push order, outputs matching each entry, final STATUS idle=1.
REQ-026 Done held high across LAUNCH into WAIT with no rising edge -> FSM stays WAIT; Done low then high -> IDLE.
REQ-027 Reset asserted mid-WAIT with 4 entries queued -> all outputs 0 immediately, occupancy 0, no Go after release.
REQ-028 Full FIFO, IDLE, pause cleared while PUSH on same cycle -> pop occurs, PUSH rejected, overflow=1, occupancy 7.
